// File: rtl/hs_beat_packer_pkg.sv
// Shared types and helpers for the beat packer: FSM state encoding,
// default geometry and the checksum accumulate step.
package hs_beat_packer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUT     = 2'd2
  } pkt_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_BEATS = 4;
  localparam int CHK_MAX_W = 32;

  // Callers truncate the result to their beat width, giving modulo-2^WIDTH.
  function automatic logic [CHK_MAX_W-1:0] chk_add(input logic [CHK_MAX_W-1:0] acc,
                                                   input logic [CHK_MAX_W-1:0] beat);
    return acc + beat;
  endfunction

endpackage

// File: rtl/hs_skid1.sv
// One-entry skid register holding a beat that arrived while the packer
// could not take it; a push into a full entry without a pop is lost.
module hs_skid1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             full_nxt,
  output logic             overflow
);

  assign full_nxt = push | (full & ~pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      full <= full_nxt;
      if (push && (!full || pop))
        dout <= din;
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/hs_beat_packer.sv
// Packs BEATS synchronizer beats into one packet with valid/ready output and
// busy backpressure. Define PKT_CHECKSUM_EN to add the out_sum checksum port.
module hs_beat_packer
  import hs_beat_packer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BEATS = DEF_BEATS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*BEATS-1:0] out_data,
`ifdef PKT_CHECKSUM_EN
  output logic [WIDTH-1:0]       out_sum,
`endif
  output logic                   overflow
);

  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BEATS);

  pkt_state_t                   state;
  logic [CNT_W-1:0]             count;
  logic [BEATS-1:0][WIDTH-1:0]  slot;
  logic                         skid_full;
  logic                         skid_full_nxt;
  logic [WIDTH-1:0]             skid_data;
  logic                         collecting;
  logic                         push;
  logic                         pop;
  logic                         cap_en;
  logic                         to_out;
  logic [WIDTH-1:0]             cap_data;

  // A held skid beat is always older than in_data, so it is captured first.
  assign collecting = (state != OUT);
  assign pop        = collecting && skid_full;
  assign push       = in_valid && (!collecting || skid_full);
  assign cap_en     = collecting && (skid_full || in_valid);
  assign cap_data   = skid_full ? skid_data : in_data;
  assign to_out     = collecting ? (cap_en && (count == LAST_CNT)) : !out_ready;
  assign out_data   = slot;

  hs_skid1 #(.WIDTH(WIDTH)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .din      (in_data),
    .dout     (skid_data),
    .full     (skid_full),
    .full_nxt (skid_full_nxt),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      slot      <= '0;
      out_valid <= 1'b0;
      in_busy   <= 1'b0;
    end else begin
      out_valid <= to_out;
      in_busy   <= to_out || skid_full_nxt;
      case (state)
        IDLE, COLLECT: begin
          if (cap_en) begin
            for (int i = 0; i < BEATS; i++)
              if (count == CNT_W'(i))
                slot[i] <= cap_data;
            if (count == LAST_CNT) begin
              state <= OUT;
              count <= FULL_CNT;
            end else begin
              state <= COLLECT;
              count <= count + CNT_W'(1);
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state <= IDLE;
            count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

`ifdef PKT_CHECKSUM_EN
  logic [WIDTH-1:0] sum_acc;

  always_ff @(posedge clk) begin
    if (rst)
      sum_acc <= '0;
    else if (cap_en)
      sum_acc <= WIDTH'(chk_add(CHK_MAX_W'(sum_acc), CHK_MAX_W'(cap_data)));
    else if (!collecting && out_ready)
      sum_acc <= '0;
  end

  assign out_sum = sum_acc;
`endif

endmodule

// File: tb/tb_hs_beat_packer.sv
// Directed and randomized bench for hs_beat_packer against a queue-based
// model of beat ordering, skid absorption, drops and packet hand-off.
module tb_hs_beat_packer;

  localparam int WIDTH = 8;
  localparam int BEATS = 4;
  localparam int PKT_W = WIDTH * BEATS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             in_busy;
  logic             out_valid;
  logic [PKT_W-1:0] out_data;
  logic             overflow;
`ifdef PKT_CHECKSUM_EN
  logic [WIDTH-1:0] out_sum;
`endif

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_asm[$];
  logic [WIDTH-1:0] m_skid[$];
  bit               m_held;
  bit               m_ovf;
  logic [PKT_W-1:0] m_pkt;
  logic [WIDTH-1:0] m_sum;

  hs_beat_packer #(.WIDTH(WIDTH), .BEATS(BEATS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_busy   (in_busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef PKT_CHECKSUM_EN
    .out_sum   (out_sum),
`endif
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_asm.delete();
    m_skid.delete();
    m_held = 0;
    m_ovf  = 0;
    m_pkt  = '0;
    m_sum  = '0;
  endtask

  // One clock edge of the packer, stated as beat-queue movements.
  task automatic model_edge(input bit iv, input logic [WIDTH-1:0] d, input bit ordy);
    if (m_held) begin
      if (iv) begin
        if (m_skid.size() == 0) m_skid.push_back(d);
        else m_ovf = 1;
      end
      if (ordy) m_held = 0;
    end else begin
      if (m_skid.size() != 0) begin
        m_asm.push_back(m_skid.pop_front());
        if (iv) m_skid.push_back(d);
      end else if (iv) begin
        m_asm.push_back(d);
      end
      if (m_asm.size() == BEATS) begin
        m_held = 1;
        m_sum  = '0;
        for (int i = 0; i < BEATS; i++) begin
          m_pkt[i*WIDTH +: WIDTH] = m_asm[i];
          m_sum = WIDTH'(m_sum + m_asm[i]);
        end
        m_asm.delete();
      end
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(m_held));
    chk("in_busy", 64'(in_busy), 64'(m_held || (m_skid.size() != 0)));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (m_held) begin
      chk("out_data", 64'(out_data), 64'(m_pkt));
`ifdef PKT_CHECKSUM_EN
      chk("out_sum", 64'(out_sum), 64'(m_sum));
`endif
    end
  endtask

  task automatic cyc(input bit iv, input logic [WIDTH-1:0] d, input bit ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    model_edge(iv, d, ordy);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_busy", 64'(in_busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
`ifdef PKT_CHECKSUM_EN
    chk("rst_out_sum", 64'(out_sum), 64'd0);
`endif
  endtask

  initial begin
    do_reset();

    // Basic packet, consumer always ready.
    cyc(1, 8'h11, 1); cyc(1, 8'h22, 1); cyc(1, 8'h33, 1); cyc(1, 8'h44, 1);
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_data", 64'(out_data), 64'h44332211);
    chk("basic_busy", 64'(in_busy), 64'd1);
`ifdef PKT_CHECKSUM_EN
    chk("basic_sum", 64'(out_sum), 64'hAA);
`endif
    cyc(0, 8'h00, 1);
    chk("basic_done_valid", 64'(out_valid), 64'd0);
    chk("basic_done_busy", 64'(in_busy), 64'd0);

    // Backpressure hold for 10 cycles.
    cyc(1, 8'hF1, 0); cyc(1, 8'hF2, 0); cyc(1, 8'hF3, 0); cyc(1, 8'hF4, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 8'h00, 0);
      chk("hold_data", 64'(out_data), 64'hF4F3F2F1);
      chk("hold_busy", 64'(in_busy), 64'd1);
    end
    cyc(0, 8'h00, 1);
    chk("hold_release_valid", 64'(out_valid), 64'd0);
    chk("hold_release_busy", 64'(in_busy), 64'd0);

    // In-flight beat lands in the skid and leads the next packet.
    cyc(1, 8'hA1, 0); cyc(1, 8'hA2, 0); cyc(1, 8'hA3, 0); cyc(1, 8'hA4, 0);
    cyc(1, 8'h55, 0);
    cyc(0, 8'h00, 1);
    chk("inflight_busy_skid", 64'(in_busy), 64'd1);
    cyc(1, 8'h66, 0); cyc(1, 8'h77, 0); cyc(1, 8'h88, 0); cyc(0, 8'h00, 0);
    chk("inflight_data", 64'(out_data), 64'h88776655);
    cyc(0, 8'h00, 1);

    // Overflow: second beat while skid is full is dropped, flag is sticky.
    cyc(1, 8'hC1, 0); cyc(1, 8'hC2, 0); cyc(1, 8'hC3, 0); cyc(1, 8'hC4, 0);
    cyc(1, 8'hA0, 0);
    cyc(1, 8'hB0, 0);
    chk("ovf_set", 64'(overflow), 64'd1);
    cyc(0, 8'h00, 1);
    cyc(1, 8'hB1, 0); cyc(1, 8'hB2, 0); cyc(1, 8'hB3, 0); cyc(0, 8'h00, 0);
    chk("ovf_next_data", 64'(out_data), 64'hB3B2B1A0);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    cyc(0, 8'h00, 1);
    do_reset();

    // Transfer with a beat into the skid, then drain alongside a new beat.
    cyc(1, 8'hD1, 0); cyc(1, 8'hD2, 0); cyc(1, 8'hD3, 0); cyc(1, 8'hD4, 0);
    cyc(1, 8'h01, 1);
    cyc(1, 8'h02, 0);
    chk("drain_busy", 64'(in_busy), 64'd1);
    cyc(1, 8'h03, 0); cyc(1, 8'h04, 0); cyc(0, 8'h00, 0);
    chk("drain_data", 64'(out_data), 64'h04030201);
    cyc(0, 8'h00, 1);

    // Reset mid-packet discards the partial packet.
    cyc(1, 8'hE1, 0); cyc(1, 8'hE2, 0);
    do_reset();
    cyc(1, 8'h01, 0); cyc(1, 8'h02, 0); cyc(1, 8'h03, 0); cyc(1, 8'h04, 0);
    chk("midrst_data", 64'(out_data), 64'h04030201);
    chk("midrst_valid", 64'(out_valid), 64'd1);
    cyc(0, 8'h00, 1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0)
        do_reset();
      else
        cyc($urandom_range(0, 99) < 45, WIDTH'($urandom), $urandom_range(0, 99) < 40);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
